// File: rtl/e_fwd_pkg.sv
// e_fwd_pkg
//   Shared types for the E-stage forwarding controller.
//   fwd_sel_e     : forwarding mux select code driven into E
//   stage_info_t  : destination info tracked per shadow pipeline slot
//   fwd_pick      : select code for one source register from the E/M slots
package e_fwd_pkg;

  // Widest register address the shadow slots can carry; narrower cores
  // zero-extend their addresses into it.
  localparam int RD_MAX_W = 8;

  typedef enum logic [1:0] {
    FWD_RS  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_ALU = 2'b10,
    FWD_MEM = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } stage_info_t;

  localparam stage_info_t BUBBLE = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

  // The E slot holds the newer producer, so it is checked first.
  function automatic fwd_sel_e fwd_pick(input stage_info_t e_slot,
                                        input stage_info_t m_slot,
                                        input logic [RD_MAX_W-1:0] rs);
    if (rs == '0)
      return FWD_RS;
    if (e_slot.regwrite && (e_slot.rd == rs))
      return e_slot.memread ? FWD_MEM : FWD_ALU;
    if (m_slot.regwrite && (m_slot.rd == rs))
      return FWD_WB;
    return FWD_RS;
  endfunction

endpackage

// File: rtl/e_fwd_track.sv
// e_fwd_track
//   Shadow copy of the destination info for the instructions in E and M.
//   Every edge the E slot moves into M and the D-stage info moves into E,
//   unless kill_e replaces it with a bubble.
// Ports
//   clk     in   clock
//   rst     in   synchronous active-high reset (both slots -> bubble)
//   info_d  in   destination info of the instruction in D
//   kill_e  in   insert a bubble into the E slot this edge
//   slot_e  out  info of the instruction now in E
//   slot_m  out  info of the instruction now in M
module e_fwd_track
  import e_fwd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  stage_info_t info_d,
  input  logic        kill_e,
  output stage_info_t slot_e,
  output stage_info_t slot_m
);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_e <= BUBBLE;
      slot_m <= BUBBLE;
    end else begin
      slot_m <= slot_e;
      slot_e <= kill_e ? BUBBLE : info_d;
    end
  end

endmodule

// File: rtl/e_fwd_ctrl.sv
// e_fwd_ctrl
//   Forwarding / hazard controller for the 5-stage core. Forwarding selects
//   are decided in D against a shadow copy of the E/M destinations and
//   registered so they are valid while the instruction sits in E. Also
//   raises load-use stall (registered data memory only), branch flush and
//   counts load-use stall cycles.
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_rs1_D, i_rs2_D       source registers of the D instruction
//   i_rd_D                 destination register of the D instruction
//   i_regwrite_D           D instruction writes rd
//   i_memread_D            D instruction is a load
//   i_pcsrc_E              taken branch/jump in E
//   o_stall_F, o_stall_D   hold PC / hold F-D register
//   o_flush_D, o_flush_E   clear F-D / D-E register
//   o_con_fa, o_con_fb     operand A/B forwarding select, valid in E
//   o_stall_cnt            number of load-use stall cycles (wrapping)
module e_fwd_ctrl
  import e_fwd_pkg::*;
#(
  parameter bit SYNC_DMEM = 1'b0,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_rs1_D,
  input  logic [REG_AW-1:0] i_rs2_D,
  input  logic [REG_AW-1:0] i_rd_D,
  input  logic              i_regwrite_D,
  input  logic              i_memread_D,
  input  logic              i_pcsrc_E,
  output logic              o_stall_F,
  output logic              o_stall_D,
  output logic              o_flush_D,
  output logic              o_flush_E,
  output logic [1:0]        o_con_fa,
  output logic [1:0]        o_con_fb,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  stage_info_t         info_d;
  stage_info_t         slot_e;
  stage_info_t         slot_m;
  logic [RD_MAX_W-1:0] rs1;
  logic [RD_MAX_W-1:0] rs2;
  logic                flush;
  logic                load_use;
  logic                kill_e;
  fwd_sel_e            sel_a;
  fwd_sel_e            sel_b;
  fwd_sel_e            con_fa;
  fwd_sel_e            con_fb;
  logic [CNT_W-1:0]    stall_cnt;

  assign rs1    = RD_MAX_W'(i_rs1_D);
  assign rs2    = RD_MAX_W'(i_rs2_D);
  assign info_d = '{rd: RD_MAX_W'(i_rd_D), regwrite: i_regwrite_D, memread: i_memread_D};

  // Flush outranks load-use: the stalled instruction is discarded anyway.
  assign flush    = i_pcsrc_E && !i_rst;
  assign load_use = SYNC_DMEM && !i_rst && !i_pcsrc_E
                    && slot_e.memread && slot_e.regwrite && (slot_e.rd != '0)
                    && ((slot_e.rd == rs1) || (slot_e.rd == rs2));
  assign kill_e   = flush || load_use;

  assign o_stall_F = load_use;
  assign o_stall_D = load_use;
  assign o_flush_D = flush;
  assign o_flush_E = kill_e;

  e_fwd_track u_track (
    .clk    (i_clk),
    .rst    (i_rst),
    .info_d (info_d),
    .kill_e (kill_e),
    .slot_e (slot_e),
    .slot_m (slot_m)
  );

  // With SYNC_DMEM=1 an E-slot load match always stalls, so FWD_MEM is
  // masked by the bubble and only WB forwarding is seen on the repeat.
  assign sel_a = fwd_pick(slot_e, slot_m, rs1);
  assign sel_b = fwd_pick(slot_e, slot_m, rs2);

  always_ff @(posedge i_clk) begin
    if (i_rst || kill_e) begin
      con_fa <= FWD_RS;
      con_fb <= FWD_RS;
    end else begin
      con_fa <= sel_a;
      con_fb <= sel_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      stall_cnt <= '0;
    else if (load_use)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign o_con_fa    = con_fa;
  assign o_con_fb    = con_fb;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_e_fwd_ctrl.sv
// Bench for e_fwd_ctrl: instance 0 with combinational data memory and a
// 32-bit counter, instance 1 with registered data memory and a 4-bit counter.
module tb_e_fwd_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  localparam ins_t NOP = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1 [2];
  logic [4:0] rs2 [2];
  logic [4:0] rd  [2];
  logic       rw  [2];
  logic       mr  [2];
  logic       pcs [2];
  logic       stall_f [2];
  logic       stall_d [2];
  logic       flush_d [2];
  logic       flush_e [2];
  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  e_fwd_ctrl #(.SYNC_DMEM(1'b0), .REG_AW(5), .CNT_W(32)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_D(rs1[0]), .i_rs2_D(rs2[0]), .i_rd_D(rd[0]),
    .i_regwrite_D(rw[0]), .i_memread_D(mr[0]), .i_pcsrc_E(pcs[0]),
    .o_stall_F(stall_f[0]), .o_stall_D(stall_d[0]),
    .o_flush_D(flush_d[0]), .o_flush_E(flush_e[0]),
    .o_con_fa(fa[0]), .o_con_fb(fb[0]), .o_stall_cnt(cnt0)
  );

  e_fwd_ctrl #(.SYNC_DMEM(1'b1), .REG_AW(5), .CNT_W(4)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_D(rs1[1]), .i_rs2_D(rs2[1]), .i_rd_D(rd[1]),
    .i_regwrite_D(rw[1]), .i_memread_D(mr[1]), .i_pcsrc_E(pcs[1]),
    .o_stall_F(stall_f[1]), .o_stall_D(stall_d[1]),
    .o_flush_D(flush_d[1]), .o_flush_E(flush_e[1]),
    .o_con_fa(fa[1]), .o_con_fb(fb[1]), .o_stall_cnt(cnt1)
  );

  int n_chk = 0;
  int n_fail = 0;

  ins_t       cur   [2];
  logic       pc_in [2];
  ins_t       hq0[$];
  ins_t       hq1[$];
  logic [1:0] efa [2];
  logic [1:0] efb [2];
  longint     ecnt [2];
  logic       lu_last [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int d, input int s1, input int s2,
                              input bit w, input bit m);
    ins_t i;
    i.rd  = 5'(d);
    i.rs1 = 5'(s1);
    i.rs2 = 5'(s2);
    i.rw  = w;
    i.mr  = m;
    return i;
  endfunction

  // h[0] is the instruction that entered E most recently, h[1] the one before.
  function automatic logic [1:0] exp_code(input ins_t h[$], input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    for (int age = 0; age < 2; age++)
      if (h[age].rw && h[age].rd == rs)
        return (age == 0) ? (h[age].mr ? 2'b11 : 2'b10) : 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    ins_t h[$];
    logic lu, fl, kill;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rs1[k] = cur[k].rs1;
      rs2[k] = cur[k].rs2;
      rd[k]  = cur[k].rd;
      rw[k]  = cur[k].rw;
      mr[k]  = cur[k].mr;
      pcs[k] = pc_in[k];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      h  = (k == 0) ? hq0 : hq1;
      fl = pc_in[k] && !rst;
      lu = (k == 1) && !rst && !pc_in[k] && h[0].mr && h[0].rw && (h[0].rd != 0)
           && ((h[0].rd == cur[k].rs1) || (h[0].rd == cur[k].rs2));
      chk($sformatf("stall_F%0d", k), stall_f[k], lu);
      chk($sformatf("stall_D%0d", k), stall_d[k], lu);
      chk($sformatf("flush_D%0d", k), flush_d[k], fl);
      chk($sformatf("flush_E%0d", k), flush_e[k], lu || fl);
      if (rst) begin
        h = {NOP, NOP};
        efa[k] = 2'b00;
        efb[k] = 2'b00;
        ecnt[k] = 0;
      end else begin
        kill = lu || fl;
        efa[k] = kill ? 2'b00 : exp_code(h, cur[k].rs1);
        efb[k] = kill ? 2'b00 : exp_code(h, cur[k].rs2);
        h.push_front(kill ? NOP : cur[k]);
        void'(h.pop_back());
        if (lu) ecnt[k]++;
      end
      if (k == 0) hq0 = h; else hq1 = h;
      lu_last[k] = lu;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("con_fa%0d", k), fa[k], efa[k]);
      chk($sformatf("con_fb%0d", k), fb[k], efb[k]);
    end
    chk("stall_cnt0", cnt0, 32'(ecnt[0]));
    chk("stall_cnt1", cnt1, 32'(ecnt[1] & 64'hF));
  endtask

  task automatic set_both(input ins_t i, input logic pc);
    cur[0] = i;  cur[1] = i;
    pc_in[0] = pc; pc_in[1] = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_both(NOP, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hq0 = {NOP, NOP};
    hq1 = {NOP, NOP};
    ecnt[0] = 0; ecnt[1] = 0;
    lu_last[0] = 1'b0; lu_last[1] = 1'b0;
    do_reset();
    chk("rst_fa0", fa[0], 2'b00);
    chk("rst_cnt1", cnt1, 4'd0);

    // back-to-back ALU dependency
    set_both(mk(5, 1, 2, 1, 0), 1'b0); tick();
    set_both(mk(6, 5, 1, 1, 0), 1'b0); tick();
    chk("t1_fa0", fa[0], 2'b10);
    chk("t1_fa1", fa[1], 2'b10);

    // distance-two dependency, then x0 producer
    do_reset();
    set_both(mk(5, 1, 2, 1, 0), 1'b0); tick();
    set_both(NOP, 1'b0);               tick();
    set_both(mk(7, 1, 5, 1, 0), 1'b0); tick();
    chk("t2_fb0", fb[0], 2'b01);
    chk("t2_fb1", fb[1], 2'b01);
    set_both(mk(0, 1, 2, 1, 0), 1'b0); tick();
    set_both(mk(6, 0, 0, 1, 0), 1'b0); tick();
    chk("t2_x0_fa", fa[0], 2'b00);
    chk("t2_x0_fb", fb[0], 2'b00);

    // load-use: memout forward vs one-cycle stall
    do_reset();
    set_both(mk(5, 1, 0, 1, 1), 1'b0); tick();
    set_both(mk(6, 5, 5, 1, 0), 1'b0); tick();
    chk("t3_fa0", fa[0], 2'b11);
    chk("t3_fb0", fb[0], 2'b11);
    chk("t3_cnt0", cnt0, 32'd0);
    chk("t3_bub_fa1", fa[1], 2'b00);
    chk("t3_cnt1", cnt1, 4'd1);
    tick();
    chk("t3_fa1", fa[1], 2'b01);
    chk("t3_fb1", fb[1], 2'b01);
    chk("t3_cnt1b", cnt1, 4'd1);

    // load-use coincident with a taken branch
    do_reset();
    set_both(mk(5, 1, 0, 1, 1), 1'b0); tick();
    set_both(mk(6, 5, 5, 1, 0), 1'b1); tick();
    chk("t4_fa1", fa[1], 2'b00);
    chk("t4_fa0", fa[0], 2'b00);
    chk("t4_cnt1", cnt1, 4'd0);
    set_both(NOP, 1'b0); tick();

    // reset in the middle of a stall
    do_reset();
    set_both(mk(5, 1, 0, 1, 1), 1'b0); tick();
    set_both(mk(6, 5, 5, 1, 0), 1'b0);
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("t5_fa1", fa[1], 2'b00);
    chk("t5_fb1", fb[1], 2'b00);
    chk("t5_cnt1", cnt1, 4'd0);
    chk("t5_stall1", stall_f[1], 1'b0);

    // 4-bit counter wrap after 16 stalls
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      set_both(mk(5, 1, 0, 1, 1), 1'b0); tick();
      set_both(mk(6, 5, 5, 1, 0), 1'b0); tick();
      tick();
      if (n == 15) chk("t6_cnt15", cnt1, 4'd15);
    end
    chk("t6_wrap", cnt1, 4'd0);

    // random traffic; a stalled instance keeps its D instruction
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!lu_last[k])
          cur[k] = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        pc_in[k] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
